// File: rtl/seq_alu_core.sv
// Clocked WIDTH-generic ALU with start/busy/done handshake.
// DIV/MOD use a restoring divider that produces one quotient bit per clock.
module seq_alu_core #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     inputA,
  input  logic [WIDTH-1:0]     inputB,
  input  logic [3:0]           opcode,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   outputC,
  output logic [1:0]           error
);

  // state   | meaning
  // IDLE    | waiting for start; operands latched on accept
  // EXEC    | single-cycle op or divide-by-zero; registers result
  // DIVLOOP | one quotient bit per cycle; registers result when count hits 0
  // DONE    | done pulse for one cycle; start ignored
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EXEC    = 2'd1;
  localparam logic [1:0] DIVLOOP = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam logic [3:0] OP_DIV = 4'b0111;
  localparam logic [3:0] OP_MOD = 4'b1000;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [2*WIDTH-1:0] outc_q, outc_d;
  logic [1:0]         err_q, err_d;

  logic               is_div_op;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff_ab;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] exec_c;
  logic [1:0]         exec_e;

  assign is_div_op = (opcode == OP_DIV) || (opcode == OP_MOD);

  assign sum     = {1'b0, a_q} + {1'b0, b_q};
  assign diff_ab = a_q - b_q;
  assign product = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // Restoring step: remainder shifts in the next dividend MSB held in quo_q.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, b_q};

  always_comb begin
    exec_c = '0;
    exec_e = 2'b00;
    case (op_q)
      OP_ADD: begin
        exec_c[WIDTH:0] = sum;
        exec_e[0]       = sum[WIDTH];
      end
      OP_SUB: begin
        exec_c[WIDTH-1:0] = diff_ab;
        exec_e[0]         = (a_q < b_q);
      end
      OP_MUL: exec_c = product;
      OP_DIV, OP_MOD: exec_e[1] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    outc_d  = outc_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d  = inputA;
          b_d  = inputB;
          op_d = opcode;
          if (is_div_op && (inputB != '0)) begin
            count_d = COUNT_INIT;
            rem_d   = '0;
            quo_d   = inputA;
            state_d = DIVLOOP;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        outc_d  = exec_c;
        err_d   = exec_e;
        state_d = DONE;
      end
      DIVLOOP: begin
        if (count_q != '0) begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          count_d = count_q - 1'b1;
        end else begin
          outc_d = '0;
          outc_d[WIDTH-1:0] = (op_q == OP_MOD) ? rem_q : quo_q;
          err_d   = 2'b00;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      outc_q  <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      outc_q  <= outc_d;
      err_q   <= err_d;
    end
  end

  assign busy    = (state_q == EXEC) || (state_q == DIVLOOP);
  assign done    = (state_q == DONE);
  assign outputC = outc_q;
  assign error   = err_q;

endmodule
